aes_axis_block_packer: RTL and testbench

AES_AXIS_BLOCK_PACKER -- requirements
Module: aes_axis_block_packer

---
 rtl/aes_pkg.sv | 32 +++
 rtl/aes_axis_block_packer.sv | 109 ++++++++++
 tb/tb_aes_axis_block_packer.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES block definitions and a helper that merges an AXIS word into a
// partially assembled 128-bit block.
package aes_pkg;

  localparam int AES_BLK_W         = 128;
  localparam int AES_WORDS_PER_BLK = 4;
  localparam int AES_WORD_W        = 32;

  typedef logic [127:0] aes_blk_t;

  // Word k occupies bits [127-32k -: 32]; with pad_above set, slots after
  // 'slot' are overwritten with pad_word so a short block is fully defined.
  function automatic aes_blk_t aes_merge_word(
    input aes_blk_t    asm_blk,
    input logic [31:0] word,
    input logic [1:0]  slot,
    input logic        pad_above,
    input logic [31:0] pad_word
  );
    aes_blk_t r;
    r = asm_blk;
    for (int k = 0; k < AES_WORDS_PER_BLK; k++) begin
      if (k == int'(slot)) begin
        r[AES_BLK_W-1-AES_WORD_W*k -: AES_WORD_W] = word;
      end else if (pad_above && (k > int'(slot))) begin
        r[AES_BLK_W-1-AES_WORD_W*k -: AES_WORD_W] = pad_word;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_axis_block_packer.sv
// Packs a 32-bit AXI-Stream plaintext stream into 128-bit AES blocks, padding
// a short final block, with a single inline output register stage.
module aes_axis_block_packer
  import aes_pkg::*;
#(
  parameter int          N        = 32,
  parameter logic [31:0] PAD_WORD = 32'h00000000
) (
  input  logic           S_AXI_clk,
  input  logic           S_AXI_reset,
  input  logic [N-1:0]   S_AXIS_tdata,
  input  logic           S_AXIS_tvalid,
  input  logic           S_AXIS_tlast,
  output logic           S_AXIS_tready,
  output logic [127:0]   blk_data,
  output logic           blk_valid,
  input  logic           blk_ready,
  output logic           blk_last,
  output logic [1:0]     blk_pad_words,
  output logic [15:0]    blk_count
);

  if (N != 32) begin : g_bad_width
    $fatal(1, "aes_axis_block_packer: N must be 32");
  end

  logic [1:0]  cnt_reg;
  logic        pend_reg;
  aes_blk_t    asm_reg;
  logic        asm_last_reg;
  logic [1:0]  asm_pad_reg;
  aes_blk_t    blk_data_reg;
  logic        blk_valid_reg;
  logic        blk_last_reg;
  logic [1:0]  blk_pad_reg;
  logic [15:0] blk_count_reg;

  logic        out_free;
  logic        tready;
  logic        accept;
  logic        completing;
  logic        load_direct;
  logic        load_pend;
  aes_blk_t    merged;

  assign out_free    = !blk_valid_reg || blk_ready;
  assign tready      = !pend_reg && ((cnt_reg != 2'd3) || out_free);
  assign accept      = S_AXIS_tvalid && tready;
  assign completing  = accept && ((cnt_reg == 2'd3) || S_AXIS_tlast);
  assign load_direct = completing && out_free;
  // pend and accept are mutually exclusive because tready is low while pending
  assign load_pend   = pend_reg && out_free;
  assign merged      = aes_merge_word(asm_reg, S_AXIS_tdata, cnt_reg, completing, PAD_WORD);

  always_ff @(posedge S_AXI_clk) begin
    if (S_AXI_reset) begin
      cnt_reg       <= 2'd0;
      pend_reg      <= 1'b0;
      asm_reg       <= '0;
      asm_last_reg  <= 1'b0;
      asm_pad_reg   <= 2'd0;
      blk_data_reg  <= '0;
      blk_valid_reg <= 1'b0;
      blk_last_reg  <= 1'b0;
      blk_pad_reg   <= 2'd0;
      blk_count_reg <= 16'd0;
    end else begin
      if (blk_valid_reg && blk_ready) begin
        blk_valid_reg <= 1'b0;
        blk_count_reg <= blk_count_reg + 16'd1;
      end
      // A new load overrides the handshake clear so valid stays high.
      if (load_direct) begin
        blk_data_reg  <= merged;
        blk_valid_reg <= 1'b1;
        blk_last_reg  <= S_AXIS_tlast;
        blk_pad_reg   <= 2'd3 - cnt_reg;
      end else if (load_pend) begin
        blk_data_reg  <= asm_reg;
        blk_valid_reg <= 1'b1;
        blk_last_reg  <= asm_last_reg;
        blk_pad_reg   <= asm_pad_reg;
        pend_reg      <= 1'b0;
      end
      if (accept) begin
        if (completing) begin
          cnt_reg <= 2'd0;
          if (!out_free) begin
            asm_reg      <= merged;
            asm_last_reg <= S_AXIS_tlast;
            asm_pad_reg  <= 2'd3 - cnt_reg;
            pend_reg     <= 1'b1;
          end
        end else begin
          asm_reg <= merged;
          cnt_reg <= cnt_reg + 2'd1;
        end
      end
    end
  end

  assign S_AXIS_tready = tready;
  assign blk_data      = blk_data_reg;
  assign blk_valid     = blk_valid_reg;
  assign blk_last      = blk_last_reg;
  assign blk_pad_words = blk_pad_reg;
  assign blk_count     = blk_count_reg;

endmodule

// File: tb/tb_aes_axis_block_packer.sv
// Scoreboard bench for aes_axis_block_packer: expected blocks are queued as
// words are accepted and compared as blocks are handed off.
module tb_aes_axis_block_packer;

  localparam logic [31:0] PAD = 32'h00000000;

  typedef struct packed {
    logic [127:0] data;
    logic         last;
    logic [1:0]   pad;
  } exp_t;

  logic         clk = 1'b0;
  logic         srst = 1'b1;
  logic [31:0]  tdata = '0;
  logic         tvalid = 1'b0;
  logic         tlast = 1'b0;
  logic         tready;
  logic [127:0] blk_data;
  logic         blk_valid;
  logic         blk_ready = 1'b0;
  logic         blk_last;
  logic [1:0]   blk_pad_words;
  logic [15:0]  blk_count;

  int           vectors = 0;
  int           miscompares = 0;
  exp_t         exp_q[$];
  logic [31:0]  mdl_words[4];
  int           mdl_cnt = 0;
  logic [15:0]  mdl_count = 16'd0;

  always #5 clk = ~clk;

  aes_axis_block_packer #(.N(32), .PAD_WORD(PAD)) dut (
    .S_AXI_clk     (clk),
    .S_AXI_reset   (srst),
    .S_AXIS_tdata  (tdata),
    .S_AXIS_tvalid (tvalid),
    .S_AXIS_tlast  (tlast),
    .S_AXIS_tready (tready),
    .blk_data      (blk_data),
    .blk_valid     (blk_valid),
    .blk_ready     (blk_ready),
    .blk_last      (blk_last),
    .blk_pad_words (blk_pad_words),
    .blk_count     (blk_count)
  );

  // One clock: observe what the next edge will sample, update the model,
  // compare any handed-off block, then step to just after the edge.
  task automatic cycle(output logic acc);
    exp_t e;
    acc = 1'b0;
    @(negedge clk);
    if (srst) begin
      mdl_cnt   = 0;
      mdl_count = 16'd0;
      exp_q.delete();
    end else begin
      if (tvalid && tready) begin
        acc = 1'b1;
        mdl_words[mdl_cnt] = tdata;
        if (mdl_cnt == 3 || tlast) begin
          e.data = '0;
          for (int k = 0; k < 4; k++)
            e.data[127-32*k -: 32] = (k <= mdl_cnt) ? mdl_words[k] : PAD;
          e.last = tlast;
          e.pad  = 2'(3 - mdl_cnt);
          exp_q.push_back(e);
          mdl_cnt = 0;
        end else begin
          mdl_cnt++;
        end
      end
      if (blk_valid && blk_ready) begin
        vectors++;
        mdl_count = mdl_count + 16'd1;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected_block got %h last=%0b pad=%0d want no block",
                   blk_data, blk_last, blk_pad_words);
          miscompares++;
        end else begin
          e = exp_q.pop_front();
          if ({blk_data, blk_last, blk_pad_words} !== {e.data, e.last, e.pad}) begin
            $display("FAIL sb_block got %h last=%0b pad=%0d want %h last=%0b pad=%0d",
                     blk_data, blk_last, blk_pad_words, e.data, e.last, e.pad);
            miscompares++;
          end else begin
            $display("block %h last=%0b pad=%0d ok", blk_data, blk_last, blk_pad_words);
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] d, input logic l, input logic rnd_ready,
                     output int cyc);
    logic acc;
    tdata  = d;
    tlast  = l;
    tvalid = 1'b1;
    cyc    = 0;
    acc    = 1'b0;
    while (!acc && cyc < 200) begin
      if (rnd_ready) blk_ready = 1'($urandom_range(0, 1));
      cycle(acc);
      cyc++;
    end
    vectors++;
    if (!acc) begin
      $display("FAIL put_timeout word %h got no accept want accept within 200 cycles", d);
      miscompares++;
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic do_reset();
    logic acc;
    srst   = 1'b1;
    tvalid = 1'b1;
    tdata  = 32'hDEADBEEF;
    cycle(acc);
    cycle(acc);
    vectors++;
    if (blk_valid !== 1'b0) begin
      $display("FAIL reset_valid got %b want 0", blk_valid);
      miscompares++;
    end
    srst   = 1'b0;
    tvalid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({tready, blk_valid, blk_count, blk_data, blk_last, blk_pad_words} !==
        {1'b1, 1'b0, 16'd0, 128'd0, 1'b0, 2'd0}) begin
      $display("FAIL reset_state got tready=%b valid=%b count=%0d data=%h last=%b pad=%0d want 1 0 0 0 0 0",
               tready, blk_valid, blk_count, blk_data, blk_last, blk_pad_words);
      miscompares++;
    end
  endtask

  task automatic test_full_block();
    int c;
    logic acc;
    do_reset();
    blk_ready = 1'b1;
    put(32'h00111111, 1'b0, 1'b0, c);
    put(32'h22222222, 1'b0, 1'b0, c);
    put(32'h33333333, 1'b0, 1'b0, c);
    vectors++;
    if (blk_valid !== 1'b0) begin
      $display("FAIL full_early_valid got %b want 0", blk_valid);
      miscompares++;
    end
    put(32'h44444444, 1'b1, 1'b0, c);
    vectors++;
    if ({blk_valid, blk_data, blk_last, blk_pad_words} !==
        {1'b1, 128'h00111111_22222222_33333333_44444444, 1'b1, 2'd0}) begin
      $display("FAIL full_block got v=%b %h last=%b pad=%0d want v=1 00111111222222223333333344444444 last=1 pad=0",
               blk_valid, blk_data, blk_last, blk_pad_words);
      miscompares++;
    end
    cycle(acc);
    vectors++;
    if ({blk_valid, blk_count} !== {1'b0, 16'd1}) begin
      $display("FAIL full_one_cycle got valid=%b count=%0d want valid=0 count=1",
               blk_valid, blk_count);
      miscompares++;
    end
  endtask

  task automatic test_short_block();
    int c;
    logic acc;
    blk_ready = 1'b1;
    put(32'hAAAAAAAA, 1'b0, 1'b0, c);
    put(32'hBBBBBBBB, 1'b1, 1'b0, c);
    vectors++;
    if ({blk_valid, blk_data, blk_last, blk_pad_words} !==
        {1'b1, 128'hAAAAAAAA_BBBBBBBB_00000000_00000000, 1'b1, 2'd2}) begin
      $display("FAIL short_block got v=%b %h last=%b pad=%0d want v=1 AAAAAAAABBBBBBBB0000000000000000 last=1 pad=2",
               blk_valid, blk_data, blk_last, blk_pad_words);
      miscompares++;
    end
    cycle(acc);
  endtask

  task automatic test_backpressure();
    int c;
    logic acc;
    logic [15:0] base;
    base = blk_count;
    blk_ready = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      if (i == 7) begin
        vectors++;
        if (tready !== 1'b1) begin
          $display("FAIL bp_tready_cnt2 got %b want 1", tready);
          miscompares++;
        end
      end
      put(32'h10000000 + 32'(i), 1'b0, 1'b0, c);
    end
    vectors++;
    if (tready !== 1'b0) begin
      $display("FAIL bp_tready_cnt3 got %b want 0", tready);
      miscompares++;
    end
    tdata  = 32'h10000008;
    tlast  = 1'b1;
    tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(acc);
      vectors++;
      if ({acc, blk_valid, blk_data} !==
          {1'b0, 1'b1, 128'h10000001_10000002_10000003_10000004}) begin
        $display("FAIL bp_hold got acc=%b v=%b %h want acc=0 v=1 10000001100000021000000310000004",
                 acc, blk_valid, blk_data);
        miscompares++;
      end
    end
    blk_ready = 1'b1;
    put(32'h10000008, 1'b1, 1'b0, c);
    vectors++;
    if ({c, blk_valid, blk_data} !== {32'd1, 1'b1, 128'h10000005_10000006_10000007_10000008}) begin
      $display("FAIL bp_second got cyc=%0d v=%b %h want cyc=1 v=1 10000005100000061000000710000008",
               c, blk_valid, blk_data);
      miscompares++;
    end
    cycle(acc);
    vectors++;
    if (blk_count !== base + 16'd2) begin
      $display("FAIL bp_count got %0d want %0d", blk_count, base + 16'd2);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid_block();
    int c;
    logic acc;
    blk_ready = 1'b1;
    put(32'hE0E0E0E0, 1'b0, 1'b0, c);
    put(32'hE1E1E1E1, 1'b0, 1'b0, c);
    do_reset();
    put(32'h0000A001, 1'b0, 1'b0, c);
    put(32'h0000A002, 1'b0, 1'b0, c);
    put(32'h0000A003, 1'b0, 1'b0, c);
    put(32'h0000A004, 1'b1, 1'b0, c);
    vectors++;
    if (blk_data !== 128'h0000A001_0000A002_0000A003_0000A004) begin
      $display("FAIL rst_mid_data got %h want 0000A0010000A0020000A0030000A004", blk_data);
      miscompares++;
    end
    cycle(acc);
    vectors++;
    if (blk_count !== 16'd1) begin
      $display("FAIL rst_mid_count got %0d want 1", blk_count);
      miscompares++;
    end
  endtask

  task automatic test_pend();
    int c;
    logic acc;
    do_reset();
    blk_ready = 1'b0;
    for (int i = 0; i < 4; i++) put(32'hC0DE0000 + 32'(i), 1'b0, 1'b0, c);
    put(32'h5A5A5A5A, 1'b1, 1'b0, c);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if ({tready, blk_data} !== {1'b0, 128'hC0DE0000_C0DE0001_C0DE0002_C0DE0003}) begin
        $display("FAIL pend_hold got tready=%b %h want tready=0 C0DE0000C0DE0001C0DE0002C0DE0003",
                 tready, blk_data);
        miscompares++;
      end
      cycle(acc);
    end
    blk_ready = 1'b1;
    cycle(acc);
    vectors++;
    if ({blk_valid, blk_data, blk_last, blk_pad_words} !==
        {1'b1, 128'h5A5A5A5A_00000000_00000000_00000000, 1'b1, 2'd3}) begin
      $display("FAIL pend_release got v=%b %h last=%b pad=%0d want v=1 5A5A5A5A000000000000000000000000 last=1 pad=3",
               blk_valid, blk_data, blk_last, blk_pad_words);
      miscompares++;
    end
    cycle(acc);
    vectors++;
    if ({tready, blk_count} !== {1'b1, 16'd2}) begin
      $display("FAIL pend_after got tready=%b count=%0d want tready=1 count=2", tready, blk_count);
      miscompares++;
    end
  endtask

  task automatic test_random();
    int c;
    int total;
    logic acc;
    for (int i = 0; i < 1000; i++)
      put($urandom, 1'($urandom_range(0, 3) == 0), 1'b1, c);
    blk_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle(acc);
    total = 0;
    for (int i = 0; i < 64; i++) begin
      put($urandom, 1'(i == 63), 1'b0, c);
      total += c;
    end
    vectors++;
    if (total !== 64) begin
      $display("FAIL rnd_throughput got %0d cycles want 64", total);
      miscompares++;
    end
    for (int i = 0; i < 4; i++) cycle(acc);
    vectors++;
    if (exp_q.size() !== 0 || blk_count !== mdl_count) begin
      $display("FAIL rnd_drain got pending=%0d count=%0d want pending=0 count=%0d",
               exp_q.size(), blk_count, mdl_count);
      miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_full_block();
    test_short_block();
    test_backpressure();
    test_reset_mid_block();
    test_pend();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
